// File: rtl/uart_bus_if_pkg.sv
// uart_bus_if_pkg: register map, STATUS bit positions and TX engine states
// shared by the UART host interface, its FIFOs and its testbench.
package uart_bus_if_pkg;

    // Register addresses on the processor I/O bus
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_BAUD_LO = 2'd2;
    localparam logic [1:0] ADDR_BAUD_HI = 2'd3;

    // STATUS register bit positions
    localparam int ST_RX_NOT_EMPTY = 0;
    localparam int ST_TX_NOT_FULL  = 1;
    localparam int ST_TX_IDLE      = 2;
    localparam int ST_RX_OVERRUN   = 3;
    localparam int ST_TX_OVERFLOW  = 4;

    // LOOPBACK bit position inside BAUD_HI
    localparam int BAUD_HI_LOOPBACK = 7;

    // TX engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_bus_if_if.sv
// uart_bus_if_if: groups the processor bus port and the UART parallel
// handshake of the host interface. The host interface uses the slave
// modport; the environment (bus master plus UART) uses the master modport.
//
// Handshakes: the processor bus is single-cycle, one access per iocs cycle,
// reads return in rdata the following cycle. TX: trmt is a one-cycle start
// request carrying tx_data, which stays stable until the transmitter raises
// tx_done (tx_done is dropped by the transmitter when it sees trmt). RX:
// rx_rdy is a level meaning rx_data is valid; the host consumes the byte and
// acknowledges with a one-cycle clr_rx_rdy pulse, after which rx_rdy drops.
interface uart_bus_if_if;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [7:0]  rx_data;
    logic [11:0] baud_goal;

    modport slave (
        input  iocs, iorw, ioaddr, wdata, tx_done, rx_rdy, rx_data,
        output rdata, trmt, tx_data, clr_rx_rdy, baud_goal
    );

    modport master (
        output iocs, iorw, ioaddr, wdata, tx_done, rx_rdy, rx_data,
        input  rdata, trmt, tx_data, clr_rx_rdy, baud_goal
    );
endinterface

// File: rtl/uart_bus_if_fifo.sv
// uart_bus_if_fifo: 8-bit synchronous FIFO, power-of-2 depth. Push and pop
// may occur in the same cycle; a push into a full FIFO is accepted only when
// a pop happens in that cycle. Popping an empty FIFO is ignored.
module uart_bus_if_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign rdata  = mem_q[rd_ptr_q];
    assign pop_ok = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Next pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_bus_if.sv
// uart_bus_if: register-mapped host interface for the UART transceiver.
// TX bytes queue in a FIFO and are sequenced to the transmitter with
// trmt/tx_done; received bytes are captured on the rising edge of rx_rdy
// into an RX FIFO and acknowledged with clr_rx_rdy. Owns baud_goal.
// Optional feature macro: UART_BUS_IF_LOOPBACK_EN (BAUD_HI bit 7 routes
// transmitted bytes straight into the RX FIFO).
module uart_bus_if
    import uart_bus_if_pkg::*;
#(
    parameter int          TX_DEPTH = 8,
    parameter int          RX_DEPTH = 8,
    parameter logic [11:0] BAUD_RST = 12'd434
) (
    input  logic         clk,
    input  logic         rst,
    uart_bus_if_if.slave bus,
    output tx_state_t    dbg_tx_state
);
    tx_state_t   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [11:0] baud_q, baud_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        rx_rdy_q, rx_rdy_qq;
`ifdef UART_BUS_IF_LOOPBACK_EN
    logic        loopback_q, loopback_d;
`endif

    logic        bus_wr, bus_rd;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_edge;
    logic [7:0]  rx_head, rx_push_data;
    logic        trmt, lb_push;
    logic [7:0]  status;

    assign bus_wr  = bus.iocs & ~bus.iorw;
    assign bus_rd  = bus.iocs & bus.iorw;
    assign tx_push = bus_wr & (bus.ioaddr == ADDR_DATA);
    assign rx_pop  = bus_rd & (bus.ioaddr == ADDR_DATA) & ~rx_empty;
    assign rx_edge = rx_rdy_q & ~rx_rdy_qq;
    // A UART byte and a loopback byte never collide: loopback yields to rx_edge
    assign rx_push      = rx_edge | lb_push;
    assign rx_push_data = rx_edge ? bus.rx_data : tx_data_q;

    uart_bus_if_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(bus.wdata),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty)
    );

    uart_bus_if_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_push_data),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // TX engine: load head byte, pulse trmt once, then wait for tx_done
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_pop    = 1'b0;
        trmt      = 1'b0;
        lb_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = START;
                end
            end
            START: begin
`ifdef UART_BUS_IF_LOOPBACK_EN
                if (loopback_q) begin
                    if (!rx_edge) begin
                        lb_push = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    trmt    = 1'b1;
                    state_d = WAIT;
                end
`else
                trmt    = 1'b1;
                state_d = WAIT;
`endif
            end
            WAIT: begin
                if (bus.tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Current STATUS view
    always_comb begin
        status                  = '0;
        status[ST_RX_NOT_EMPTY] = ~rx_empty;
        status[ST_TX_NOT_FULL]  = ~tx_full;
        status[ST_TX_IDLE]      = tx_empty & (state_q == IDLE);
        status[ST_RX_OVERRUN]   = rx_ovr_q;
        status[ST_TX_OVERFLOW]  = tx_ovf_q;
    end

    // Register file: read mux, writes, sticky error flags (a new error wins over a clearing read)
    always_comb begin
        rdata_d  = rdata_q;
        baud_d   = baud_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovr_d = rx_ovr_q;
`ifdef UART_BUS_IF_LOOPBACK_EN
        loopback_d = loopback_q;
`endif
        if (bus_rd) begin
            case (bus.ioaddr)
                ADDR_DATA:    rdata_d = rx_empty ? 8'h00 : rx_head;
                ADDR_STATUS: begin
                    rdata_d  = status;
                    tx_ovf_d = 1'b0;
                    rx_ovr_d = 1'b0;
                end
                ADDR_BAUD_LO: rdata_d = baud_q[7:0];
`ifdef UART_BUS_IF_LOOPBACK_EN
                default:      rdata_d = {loopback_q, 3'b000, baud_q[11:8]};
`else
                default:      rdata_d = {4'b0000, baud_q[11:8]};
`endif
            endcase
        end
        if (bus_wr) begin
            if (bus.ioaddr == ADDR_BAUD_LO) baud_d[7:0] = bus.wdata;
            if (bus.ioaddr == ADDR_BAUD_HI) begin
                baud_d[11:8] = bus.wdata[3:0];
`ifdef UART_BUS_IF_LOOPBACK_EN
                loopback_d   = bus.wdata[BAUD_HI_LOOPBACK];
`endif
            end
        end
        if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
        if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    end

    // State and register flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            rdata_q   <= 8'h00;
            baud_q    <= BAUD_RST;
            tx_ovf_q  <= 1'b0;
            rx_ovr_q  <= 1'b0;
            rx_rdy_q  <= 1'b0;
            rx_rdy_qq <= 1'b0;
`ifdef UART_BUS_IF_LOOPBACK_EN
            loopback_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rdata_q   <= rdata_d;
            baud_q    <= baud_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_ovr_q  <= rx_ovr_d;
            rx_rdy_q  <= bus.rx_rdy;
            rx_rdy_qq <= rx_rdy_q;
`ifdef UART_BUS_IF_LOOPBACK_EN
            loopback_q <= loopback_d;
`endif
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.trmt       = trmt;
    assign bus.tx_data    = tx_data_q;
    assign bus.clr_rx_rdy = rx_edge;
    assign bus.baud_goal  = baud_q;
    assign dbg_tx_state   = state_q;

endmodule

// File: tb/tb_uart_bus_if.sv
// tb_uart_bus_if: self-checking bench for uart_bus_if with a behavioural
// UART model (tx_done after a programmable delay, rx_rdy/clr_rx_rdy) and
// queue-based expectations for the TX and RX byte streams.
module tb_uart_bus_if;
    import uart_bus_if_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    tx_state_t dbg_state;

    uart_bus_if_if bus_i ();

    uart_bus_if #(.TX_DEPTH(8), .RX_DEPTH(8), .BAUD_RST(12'd434)) dut (
        .clk(clk), .rst(rst), .bus(bus_i), .dbg_tx_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- UART model ----------------
    int         tx_delay   = 100;
    bit         tx_stall   = 1'b0;
    bit         tx_pending = 1'b0;
    int         tx_due     = 0;
    int         trmt_cnt   = 0;
    int         clr_cnt    = 0;
    int         last_wr_cyc = 0;
    logic [7:0] tx_log[$];
    int         trmt_cyc_q[$];
    int         done_cyc_q[$];

    initial begin
        bus_i.tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus_i.tx_done = 1'b0;
                tx_pending    = 1'b0;
            end else begin
                if (bus_i.trmt === 1'b1) begin
                    trmt_cnt++;
                    tx_log.push_back(bus_i.tx_data);
                    trmt_cyc_q.push_back(cyc);
                    bus_i.tx_done = 1'b0;
                    tx_pending    = 1'b1;
                    tx_due        = cyc + tx_delay;
                end else if (tx_pending && !tx_stall && cyc >= tx_due) begin
                    bus_i.tx_done = 1'b1;
                    tx_pending    = 1'b0;
                    done_cyc_q.push_back(cyc);
                end
                if (bus_i.clr_rx_rdy === 1'b1) clr_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus_i.iocs = 1'b0; bus_i.iorw = 1'b0; bus_i.ioaddr = 2'd0; bus_i.wdata = 8'h00;
        bus_i.rx_rdy = 1'b0; bus_i.rx_data = 8'h00;
        tx_stall = 1'b0; tx_delay = 100;
        repeat (2) tick();
        tx_log.delete(); trmt_cyc_q.delete(); done_cyc_q.delete();
        trmt_cnt = 0; clr_cnt = 0;
        rst = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_i.iocs = 1'b1; bus_i.iorw = 1'b0; bus_i.ioaddr = a; bus_i.wdata = d;
        last_wr_cyc = cyc;
        tick();
        bus_i.iocs = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_i.iocs = 1'b1; bus_i.iorw = 1'b1; bus_i.ioaddr = a;
        tick();
        d = bus_i.rdata;
        bus_i.iocs = 1'b0; bus_i.iorw = 1'b0;
    endtask

    // Present one byte on rx_rdy and hold it until acknowledged (bounded)
    task automatic send_rx(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        bus_i.rx_data = d; bus_i.rx_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_i.clr_rx_rdy === 1'b1) begin ok = 1'b1; break; end
        end
        tick();
        bus_i.rx_rdy = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] r;
        apply_reset();
        n_cmp++; if (bus_i.trmt !== 1'b0) begin n_bad++; $display("FAIL reset_trmt got %b want 0", bus_i.trmt); end
        n_cmp++; if (bus_i.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h want 00", bus_i.tx_data); end
        n_cmp++; if (bus_i.clr_rx_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_clr got %b want 0", bus_i.clr_rx_rdy); end
        n_cmp++; if (bus_i.baud_goal !== 12'd434) begin n_bad++; $display("FAIL reset_baud got %0d want 434", bus_i.baud_goal); end
        n_cmp++; if (bus_i.rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", bus_i.rdata); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL reset_status got %h want 06", r); end
        bus_read(ADDR_BAUD_LO, r);
        n_cmp++; if (r !== 8'hB2) begin n_bad++; $display("FAIL reset_baud_lo got %h want b2", r); end
        bus_read(ADDR_BAUD_HI, r);
        n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL reset_baud_hi got %h want 01", r); end
        bus_read(ADDR_DATA, r);
        n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL reset_data_empty got %h want 00", r); end
    endtask

    task automatic test_tx_basic();
        logic [7:0] r;
        int w0, n;
        apply_reset();
        tx_delay = 100;
        bus_write(ADDR_DATA, 8'h55);
        w0 = last_wr_cyc;
        bus_write(ADDR_DATA, 8'hAA);
        n = 0;
        while (done_cyc_q.size() < 2 && n < 600) begin tick(); n++; end
        n_cmp++; if (n >= 600) begin n_bad++; $display("FAIL tx_basic_timeout got %0d dones want 2", done_cyc_q.size()); end
        repeat (20) tick();
        n_cmp++; if (trmt_cnt !== 2) begin n_bad++; $display("FAIL tx_basic_count got %0d want 2", trmt_cnt); end
        if (tx_log.size() >= 2 && trmt_cyc_q.size() >= 2 && done_cyc_q.size() >= 1) begin
            n_cmp++; if (tx_log[0] !== 8'h55) begin n_bad++; $display("FAIL tx_basic_b0 got %h want 55", tx_log[0]); end
            n_cmp++; if (tx_log[1] !== 8'hAA) begin n_bad++; $display("FAIL tx_basic_b1 got %h want aa", tx_log[1]); end
            n_cmp++; if (trmt_cyc_q[0] - w0 !== 2) begin n_bad++; $display("FAIL tx_first_latency got %0d want 2", trmt_cyc_q[0] - w0); end
            n_cmp++; if (trmt_cyc_q[1] - done_cyc_q[0] !== 2) begin n_bad++; $display("FAIL tx_gap got %0d want 2", trmt_cyc_q[1] - done_cyc_q[0]); end
        end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL tx_basic_status got %h want 06", r); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] exp_q[$];
        logic [7:0] r, b;
        int n;
        apply_reset();
        tx_stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_write(ADDR_DATA, b);
        end
        repeat (5) tick();
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL ovf_full_status got %h want 00", r); end
        bus_write(ADDR_DATA, 8'($urandom));
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h10) begin n_bad++; $display("FAIL ovf_sticky got %h want 10", r); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL ovf_cleared got %h want 00", r); end
        n_cmp++; if (trmt_cnt !== 1) begin n_bad++; $display("FAIL ovf_stalled_trmt got %0d want 1", trmt_cnt); end
        tx_delay = $urandom_range(2, 15);
        tx_stall = 1'b0;
        n = 0;
        while (done_cyc_q.size() < 9 && n < 2000) begin tick(); n++; end
        n_cmp++; if (n >= 2000) begin n_bad++; $display("FAIL ovf_drain_timeout got %0d dones want 9", done_cyc_q.size()); end
        repeat (5) tick();
        n_cmp++; if (trmt_cnt !== 9) begin n_bad++; $display("FAIL ovf_drain_count got %0d want 9", trmt_cnt); end
        for (int i = 0; i < 9 && i < tx_log.size(); i++) begin
            n_cmp++; if (tx_log[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovf_byte%0d got %h want %h", i, tx_log[i], exp_q[i]); end
        end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL ovf_final_status got %h want 06", r); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] r;
        bit ok;
        int timeouts;
        apply_reset();
        timeouts = 0;
        for (int i = 1; i <= 9; i++) begin
            send_rx(8'(i), ok);
            if (!ok) timeouts++;
        end
        n_cmp++; if (timeouts !== 0) begin n_bad++; $display("FAIL rx_ack_timeouts got %0d want 0", timeouts); end
        n_cmp++; if (clr_cnt !== 9) begin n_bad++; $display("FAIL rx_clr_count got %0d want 9", clr_cnt); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h0F) begin n_bad++; $display("FAIL rx_overrun_status got %h want 0f", r); end
        for (int i = 1; i <= 9; i++) begin
            bus_read(ADDR_DATA, r);
            n_cmp++; if (r !== ((i <= 8) ? 8'(i) : 8'h00)) begin n_bad++; $display("FAIL rx_read%0d got %h want %h", i, r, (i <= 8) ? 8'(i) : 8'h00); end
        end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL rx_overrun_cleared got %h want 06", r); end
    endtask

    task automatic test_rx_latency();
        logic [7:0] r, b;
        apply_reset();
        b = 8'($urandom);
        bus_i.rx_data = b; bus_i.rx_rdy = 1'b1;
        tick();
        n_cmp++; if (bus_i.clr_rx_rdy !== 1'b1) begin n_bad++; $display("FAIL rx_clr_n1 got %b want 1", bus_i.clr_rx_rdy); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL rx_status_n1 got %h want 06", r); end
        n_cmp++; if (bus_i.clr_rx_rdy !== 1'b0) begin n_bad++; $display("FAIL rx_clr_n2 got %b want 0", bus_i.clr_rx_rdy); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h07) begin n_bad++; $display("FAIL rx_status_n2 got %h want 07", r); end
        bus_i.rx_rdy = 1'b0;
        tick();
        bus_read(ADDR_DATA, r);
        n_cmp++; if (r !== b) begin n_bad++; $display("FAIL rx_latency_data got %h want %h", r, b); end
    endtask

    task automatic test_rx_pop_push();
        logic [7:0] rx_model[$];
        logic [7:0] r, b;
        bit ok;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            rx_model.push_back(b);
            send_rx(b, ok);
        end
        b = 8'($urandom);
        bus_i.rx_data = b; bus_i.rx_rdy = 1'b1;
        tick();
        n_cmp++; if (bus_i.clr_rx_rdy !== 1'b1) begin n_bad++; $display("FAIL pp_clr got %b want 1", bus_i.clr_rx_rdy); end
        bus_read(ADDR_DATA, r);
        n_cmp++; if (r !== rx_model[0]) begin n_bad++; $display("FAIL pp_pop got %h want %h", r, rx_model[0]); end
        void'(rx_model.pop_front());
        rx_model.push_back(b);
        tick();
        bus_i.rx_rdy = 1'b0;
        tick();
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h07) begin n_bad++; $display("FAIL pp_status got %h want 07", r); end
        for (int i = 0; i < 9; i++) begin
            bus_read(ADDR_DATA, r);
            if (rx_model.size() > 0) begin
                n_cmp++; if (r !== rx_model[0]) begin n_bad++; $display("FAIL pp_read%0d got %h want %h", i, r, rx_model[0]); end
                void'(rx_model.pop_front());
            end else begin
                n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL pp_read_empty got %h want 00", r); end
            end
        end
    endtask

    task automatic test_baud();
        logic [7:0]  r;
        logic [11:0] v;
        logic [2:0]  junk;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            v = 12'($urandom_range(0, 4095));
            junk = 3'($urandom);
            bus_write(ADDR_BAUD_LO, v[7:0]);
            bus_write(ADDR_BAUD_HI, {1'b0, junk, v[11:8]});
            n_cmp++; if (bus_i.baud_goal !== v) begin n_bad++; $display("FAIL baud_out got %h want %h", bus_i.baud_goal, v); end
            bus_read(ADDR_BAUD_LO, r);
            n_cmp++; if (r !== v[7:0]) begin n_bad++; $display("FAIL baud_lo got %h want %h", r, v[7:0]); end
            bus_read(ADDR_BAUD_HI, r);
            n_cmp++; if (r !== {4'h0, v[11:8]}) begin n_bad++; $display("FAIL baud_hi got %h want %h", r, {4'h0, v[11:8]}); end
        end
    endtask

    task automatic test_random_traffic();
        logic [7:0] exp_q[$];
        logic [7:0] rx_model[$];
        logic [7:0] r, b, e;
        bit ok;
        int nb, nr, nrd, n;
        apply_reset();
        for (int round = 0; round < 4; round++) begin
            tx_delay = $urandom_range(1, 30);
            nb = $urandom_range(1, 8);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(ADDR_DATA, b);
            end
            nr = $urandom_range(0, 8 - rx_model.size());
            for (int i = 0; i < nr; i++) begin
                b = 8'($urandom);
                rx_model.push_back(b);
                send_rx(b, ok);
            end
            nrd = $urandom_range(0, 9);
            for (int i = 0; i < nrd; i++) begin
                e = (rx_model.size() > 0) ? rx_model.pop_front() : 8'h00;
                bus_read(ADDR_DATA, r);
                n_cmp++; if (r !== e) begin n_bad++; $display("FAIL rand_rx r%0d got %h want %h", round, r, e); end
            end
            n = 0;
            while (done_cyc_q.size() < exp_q.size() && n < 2000) begin tick(); n++; end
            n_cmp++; if (n >= 2000) begin n_bad++; $display("FAIL rand_tx_timeout got %0d want %0d", done_cyc_q.size(), exp_q.size()); end
        end
        repeat (5) tick();
        n_cmp++; if (tx_log.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_tx_count got %0d want %0d", tx_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            n_cmp++; if (tx_log[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_tx_byte%0d got %h want %h", i, tx_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r;
        int c;
        apply_reset();
        tx_delay = 100;
        for (int i = 0; i < 3; i++) bus_write(ADDR_DATA, 8'($urandom_range(1, 255)));
        bus_write(ADDR_BAUD_LO, 8'h55);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_i.tx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_tx_data got %h want 00", bus_i.tx_data); end
        n_cmp++; if (bus_i.baud_goal !== 12'd434) begin n_bad++; $display("FAIL midrst_baud got %0d want 434", bus_i.baud_goal); end
        n_cmp++; if (dbg_state !== IDLE) begin n_bad++; $display("FAIL midrst_state got %0d want IDLE", dbg_state); end
        tick();
        rst = 1'b0;
        c = trmt_cnt;
        tick();
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL midrst_status got %h want 06", r); end
        repeat (10) tick();
        n_cmp++; if (trmt_cnt !== c) begin n_bad++; $display("FAIL midrst_queue_lost got %0d want %0d", trmt_cnt, c); end
    endtask

`ifdef UART_BUS_IF_LOOPBACK_EN
    task automatic test_loopback();
        logic [7:0] r;
        apply_reset();
        bus_write(ADDR_BAUD_HI, 8'h81);
        bus_read(ADDR_BAUD_HI, r);
        n_cmp++; if (r !== 8'h81) begin n_bad++; $display("FAIL lb_reg got %h want 81", r); end
        bus_write(ADDR_DATA, 8'h3C);
        repeat (10) tick();
        n_cmp++; if (trmt_cnt !== 0) begin n_bad++; $display("FAIL lb_no_trmt got %0d want 0", trmt_cnt); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h07) begin n_bad++; $display("FAIL lb_status got %h want 07", r); end
        bus_read(ADDR_DATA, r);
        n_cmp++; if (r !== 8'h3C) begin n_bad++; $display("FAIL lb_data got %h want 3c", r); end
    endtask
`else
    task automatic test_loopback();
        logic [7:0] r;
        apply_reset();
        bus_write(ADDR_BAUD_HI, 8'h81);
        bus_read(ADDR_BAUD_HI, r);
        n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL lb_off_reg got %h want 01", r); end
        tx_delay = 5;
        bus_write(ADDR_DATA, 8'h3C);
        repeat (20) tick();
        n_cmp++; if (trmt_cnt !== 1) begin n_bad++; $display("FAIL lb_off_trmt got %0d want 1", trmt_cnt); end
        bus_read(ADDR_STATUS, r);
        n_cmp++; if (r !== 8'h06) begin n_bad++; $display("FAIL lb_off_status got %h want 06", r); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_overrun();
        test_rx_latency();
        test_rx_pop_push();
        test_baud();
        test_random_traffic();
        test_reset_midframe();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got time limit want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
